// File: rtl/isp_bnr_ctrl.sv
// -----------------------------------------------------------------------------
// isp_bnr_ctrl
//
// Control block for the Bayer noise-reduction filter. It holds the NR level
// requested by software and only hands it to the filter at the start of a
// frame, so a frame is never processed with two different strengths. It also
// tracks the raw stream timing (pixels per line, lines per frame, frame
// count) and flags lines/frames whose geometry differs from the expected
// WIDTH x HEIGHT.
//
// Ports
//   pclk          pixel clock, all logic on its rising edge
//   rst           synchronous active-high reset
//   cfg_we        one-cycle write strobe for cfg_nr_level
//   cfg_nr_level  requested NR level (0-4, anything else is stored as 0)
//   err_clr       clears the sticky error flags
//   in_href       line-valid of the raw stream
//   in_vsync      frame sync of the raw stream, active-high
//   nr_level      frame-stable NR level to the filter
//   cfg_pending   a written level is waiting for the next frame start
//   frame_active  timing FSM is inside the active part of a frame
//   line_cnt      completed lines in the current frame
//   frame_cnt     completed frames since reset (wraps)
//   err_width     sticky: a line length differed from WIDTH
//   err_height    sticky: a frame line count differed from HEIGHT
// -----------------------------------------------------------------------------
module isp_bnr_ctrl #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int CW     = 12
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_nr_level,
  input  logic          err_clr,
  input  logic          in_href,
  input  logic          in_vsync,
  output logic [3:0]    nr_level,
  output logic          cfg_pending,
  output logic          frame_active,
  output logic [CW-1:0] line_cnt,
  output logic [15:0]   frame_cnt,
  output logic          err_width,
  output logic          err_height
);

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,  // after reset: no frame reference yet
    ST_VBLANK  = 2'd1,  // between frame start and first line
    ST_ACTIVE  = 2'd2   // lines are flowing
  } state_e;

  localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
  localparam logic [CW-1:0] HEIGHT_C = CW'(HEIGHT);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [3:0]    LVL_MAX  = 4'd4;

  state_e        state_q, state_d;
  logic          href_q, vsync_q;
  logic [CW-1:0] pix_q, pix_d;
  logic [CW-1:0] line_q, line_d;
  logic [15:0]   frame_q, frame_d;
  logic [3:0]    nr_q, nr_d;
  logic [3:0]    pend_val_q, pend_val_d;
  logic          pend_q, pend_d;
  logic          ew_q, ew_d;
  logic          eh_q, eh_d;
  logic          fact_q, fact_d;

  logic          vs_rise;
  logic          href_fall;
  logic [3:0]    cfg_level_san;

  assign vs_rise       = in_vsync & ~vsync_q;
  assign href_fall     = ~in_href & href_q;
  assign cfg_level_san = (cfg_nr_level <= LVL_MAX) ? cfg_nr_level : 4'd0;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; otherwise any
    // path that skips an assignment would infer a latch.
    state_d    = state_q;
    pix_d      = pix_q;
    line_d     = line_q;
    frame_d    = frame_q;
    nr_d       = nr_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    ew_d       = ew_q;
    eh_d       = eh_q;

    // Software write lands in the pending register; a later write overwrites.
    if (cfg_we) begin
      pend_val_d = cfg_level_san;
      pend_d     = 1'b1;
    end

    // Frame start is the only moment the filter level may change. A write
    // arriving on that very edge is taken directly and never shows as pending.
    if (vs_rise) begin
      if (cfg_we) begin
        nr_d = cfg_level_san;
      end else if (pend_q) begin
        nr_d = pend_val_q;
      end
      pend_d = 1'b0;
    end

    // Clear goes first so an error detected in the same cycle overrides it.
    if (err_clr) begin
      ew_d = 1'b0;
      eh_d = 1'b0;
    end

    unique case (state_q)
      ST_WAIT_VS: begin
        // No frame reference yet: stream activity is not trusted.
        pix_d  = '0;
        line_d = '0;
        if (vs_rise) begin
          state_d = ST_VBLANK;
        end
      end

      ST_VBLANK, ST_ACTIVE: begin
        if (href_fall) begin
          pix_d = '0;
          // A line ending inside the sync pulse belongs to no frame.
          if (!in_vsync) begin
            if (pix_q != WIDTH_C) begin
              ew_d = 1'b1;
            end
            if (line_q != CNT_MAX) begin
              line_d = line_q + 1'b1;
            end
          end
        end else if (in_href && (pix_q != CNT_MAX)) begin
          pix_d = pix_q + 1'b1;
        end

        if (state_q == ST_VBLANK) begin
          if (in_href) begin
            state_d = ST_ACTIVE;
          end
        end else if (vs_rise) begin
          if (line_q != HEIGHT_C) begin
            eh_d = 1'b1;
          end
          frame_d = frame_q + 16'd1;
          line_d  = '0;
          state_d = ST_VBLANK;
        end
      end

      default: begin
        state_d = ST_WAIT_VS;
      end
    endcase

    fact_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge pclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      state_q    <= ST_WAIT_VS;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      frame_q    <= '0;
      nr_q       <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      ew_q       <= 1'b0;
      eh_q       <= 1'b0;
      fact_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      href_q     <= in_href;
      vsync_q    <= in_vsync;
      pix_q      <= pix_d;
      line_q     <= line_d;
      frame_q    <= frame_d;
      nr_q       <= nr_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      ew_q       <= ew_d;
      eh_q       <= eh_d;
      fact_q     <= fact_d;
    end
  end

  assign nr_level     = nr_q;
  assign cfg_pending  = pend_q;
  assign frame_active = fact_q;
  assign line_cnt     = line_q;
  assign frame_cnt    = frame_q;
  assign err_width    = ew_q;
  assign err_height   = eh_q;

endmodule

// File: tb/tb_isp_bnr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_isp_bnr_ctrl
//
// Self-checking bench for isp_bnr_ctrl with an 8 x 4 frame geometry.
// Expected output values are queued as stimulus is applied and compared
// against the DUT once the corresponding clock edge has passed.
// -----------------------------------------------------------------------------
module tb_isp_bnr_ctrl;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int CW     = 12;

  typedef enum logic [2:0] {
    O_NR, O_PEND, O_FACT, O_LINE, O_FRAME, O_EW, O_EH
  } obs_e;

  typedef struct {
    string       tag;
    obs_e        sel;
    logic [31:0] val;
  } exp_t;

  logic          pclk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [3:0]    cfg_nr_level;
  logic          err_clr;
  logic          in_href;
  logic          in_vsync;
  logic [3:0]    nr_level;
  logic          cfg_pending;
  logic          frame_active;
  logic [CW-1:0] line_cnt;
  logic [15:0]   frame_cnt;
  logic          err_width;
  logic          err_height;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  isp_bnr_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_nr_level (cfg_nr_level),
    .err_clr      (err_clr),
    .in_href      (in_href),
    .in_vsync     (in_vsync),
    .nr_level     (nr_level),
    .cfg_pending  (cfg_pending),
    .frame_active (frame_active),
    .line_cnt     (line_cnt),
    .frame_cnt    (frame_cnt),
    .err_width    (err_width),
    .err_height   (err_height)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input obs_e s);
    case (s)
      O_NR:    return 32'(nr_level);
      O_PEND:  return 32'(cfg_pending);
      O_FACT:  return 32'(frame_active);
      O_LINE:  return 32'(line_cnt);
      O_FRAME: return 32'(frame_cnt);
      O_EW:    return 32'(err_width);
      default: return 32'(err_height);
    endcase
  endfunction

  task automatic expect_val(input string tag, input obs_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Compare everything queued against the current (post-edge) outputs.
  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, obs_of(e.sel), e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic expect_reset(input string tag);
    expect_val({tag, "_nr"},    O_NR,    0);
    expect_val({tag, "_pend"},  O_PEND,  0);
    expect_val({tag, "_fact"},  O_FACT,  0);
    expect_val({tag, "_line"},  O_LINE,  0);
    expect_val({tag, "_frame"}, O_FRAME, 0);
    expect_val({tag, "_ew"},    O_EW,    0);
    expect_val({tag, "_eh"},    O_EH,    0);
  endtask

  // One line of npix href-high cycles followed by two blank cycles;
  // clr asserts err_clr on the cycle where href falls.
  task automatic line(input int npix, input logic clr);
    in_href = 1'b1;
    tick(npix);
    in_href = 1'b0;
    err_clr = clr;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  task automatic cfg_write(input logic [3:0] lvl);
    cfg_we       = 1'b1;
    cfg_nr_level = lvl;
    tick(1);
    cfg_we       = 1'b0;
    tick(1);
  endtask

  // Raise vsync and stop one cycle after its rising edge was sampled.
  task automatic vs_rise_now();
    in_vsync = 1'b1;
    tick(1);
  endtask

  task automatic vs_end();
    tick(1);
    in_vsync = 1'b0;
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    cfg_we       = 1'b0;
    cfg_nr_level = 4'd0;
    err_clr      = 1'b0;
    in_href      = 1'b0;
    in_vsync     = 1'b0;
    tick(3);
    expect_reset("rst");
    drain();
    rst = 1'b0;
    tick(1);

    // Lines before any vsync are ignored, including a short one.
    line(8, 1'b0);
    line(5, 1'b0);
    line(8, 1'b0);
    expect_val("prevs_ew",    O_EW,    0);
    expect_val("prevs_eh",    O_EH,    0);
    expect_val("prevs_frame", O_FRAME, 0);
    expect_val("prevs_line",  O_LINE,  0);
    expect_val("prevs_fact",  O_FACT,  0);
    drain();

    // First vsync leaves WAIT_VS without counting a frame.
    vs_rise_now();
    expect_val("vs0_frame", O_FRAME, 0);
    expect_val("vs0_fact",  O_FACT,  0);
    drain();
    vs_end();

    // Frame 1 with a level write in the middle.
    line(8, 1'b0);
    expect_val("f1_fact", O_FACT, 1);
    expect_val("f1_line", O_LINE, 1);
    drain();
    cfg_write(4'd3);
    expect_val("w3_pend", O_PEND, 1);
    expect_val("w3_nr",   O_NR,   0);
    drain();
    for (int i = 0; i < 3; i++) line(8, 1'b0);
    expect_val("f1_line4", O_LINE, 4);
    expect_val("f1_nr_hold", O_NR, 0);
    drain();
    vs_rise_now();
    expect_val("c3_nr",    O_NR,    3);
    expect_val("c3_pend",  O_PEND,  0);
    expect_val("f1_frame", O_FRAME, 1);
    expect_val("f1_clrl",  O_LINE,  0);
    expect_val("f1_eh",    O_EH,    0);
    expect_val("f1_factv", O_FACT,  0);
    drain();
    vs_end();

    // Frame 2, clean.
    for (int i = 0; i < 4; i++) line(8, 1'b0);
    expect_val("f2_line4", O_LINE, 4);
    drain();
    vs_rise_now();
    expect_val("f2_frame", O_FRAME, 2);
    expect_val("f2_eh",    O_EH,    0);
    expect_val("f2_ew",    O_EW,    0);
    drain();
    vs_end();

    // Several writes: only the last one (9 -> sanitised 0) is committed.
    cfg_write(4'd2);
    cfg_write(4'd4);
    cfg_write(4'd9);
    expect_val("w249_pend", O_PEND, 1);
    expect_val("w249_nr",   O_NR,   3);
    drain();
    vs_rise_now();
    expect_val("c9_nr",      O_NR,    0);
    expect_val("c9_pend",    O_PEND,  0);
    expect_val("vblank_frm", O_FRAME, 2);
    drain();
    vs_end();

    // Write coincident with the vsync rising edge is committed directly.
    in_vsync     = 1'b1;
    cfg_we       = 1'b1;
    cfg_nr_level = 4'd1;
    tick(1);
    cfg_we       = 1'b0;
    expect_val("co1_nr",   O_NR,   1);
    expect_val("co1_pend", O_PEND, 0);
    drain();
    vs_end();

    // Short line, then a frame of 5 lines.
    line(7, 1'b0);
    expect_val("short_ew",   O_EW,   1);
    expect_val("short_line", O_LINE, 1);
    drain();
    for (int i = 0; i < 4; i++) line(8, 1'b0);
    expect_val("f5_line", O_LINE, 5);
    drain();
    vs_rise_now();
    expect_val("f5_eh",    O_EH,    1);
    expect_val("f5_frame", O_FRAME, 3);
    expect_val("f5_ew",    O_EW,    1);
    drain();
    vs_end();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    expect_val("clr_ew", O_EW, 0);
    expect_val("clr_eh", O_EH, 0);
    drain();

    // A line ending while vsync is high is neither counted nor checked.
    in_vsync = 1'b1;
    tick(1);
    in_href = 1'b1;
    tick(3);
    in_href = 1'b0;
    tick(2);
    expect_val("vsh_line", O_LINE, 0);
    expect_val("vsh_ew",   O_EW,   0);
    drain();
    in_vsync = 1'b0;
    tick(2);

    // Error set on the same cycle as err_clr keeps the flag.
    line(6, 1'b1);
    expect_val("clrwin_ew",   O_EW,   1);
    expect_val("clrwin_line", O_LINE, 1);
    drain();
    vs_rise_now();
    expect_val("f1l_eh",    O_EH,    1);
    expect_val("f1l_frame", O_FRAME, 4);
    drain();
    vs_end();

    // Reset in the middle of a line with a write pending.
    cfg_write(4'd2);
    in_href = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    expect_reset("mrst");
    drain();
    rst = 1'b0;
    tick(3);
    in_href = 1'b0;
    tick(3);
    expect_val("post_rst_ew",   O_EW,   0);
    expect_val("post_rst_line", O_LINE, 0);
    drain();
    vs_rise_now();
    vs_end();
    for (int i = 0; i < 4; i++) line(8, 1'b0);
    vs_rise_now();
    expect_val("rf_frame", O_FRAME, 1);
    expect_val("rf_eh",    O_EH,    0);
    expect_val("rf_ew",    O_EW,    0);
    expect_val("rf_nr",    O_NR,    0);
    drain();
    vs_end();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
